// File: rtl/rgb_ctrl_pkg.sv
// rtl/rgb_ctrl_pkg.sv - shared FSM type, fade step helper and gamma-2.2 LUT for the RGB fade sequencer
package rgb_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } fade_state_t;

    typedef logic [255:0][7:0] gamma_lut_t;

    // round(255*(i/255)^2.2) in exact integer arithmetic, so no real maths is needed:
    // the rounded value v is the largest one with (2v-1)^5 * 255^6 <= 32 * i^11.
    function automatic gamma_lut_t gen_gamma_lut();
        gamma_lut_t   lut;
        logic [127:0] den;
        logic [127:0] num;
        logic [127:0] lhs;
        logic [127:0] odd;
        logic [7:0]   val;
        logic [7:0]   cand;
        lut = '0;
        den = 128'd1;
        for (int n = 0; n < 6; n++) den = den * 128'd255;
        for (int i = 0; i < 256; i++) begin
            num = 128'd32;
            for (int n = 0; n < 11; n++) num = num * 128'(i);
            val = 8'd0;
            for (int b = 7; b >= 0; b--) begin
                cand = val | (8'd1 << b);
                odd  = {119'd0, cand, 1'b0} - 128'd1;
                lhs  = den;
                for (int n = 0; n < 5; n++) lhs = lhs * odd;
                if (lhs <= num) val = cand;
            end
            lut[8'(i)] = val;
        end
        return lut;
    endfunction

    localparam gamma_lut_t GAMMA_LUT = gen_gamma_lut();

    // One LSB toward the target; equality holds, so the level can never wrap.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) return cur + 8'd1;
        if (cur > tgt) return cur - 8'd1;
        return cur;
    endfunction

endpackage

// File: rtl/rgb_fade_ctrl_if.sv
// rtl/rgb_fade_ctrl_if.sv - colour command handshake between host and fade sequencer
interface rgb_fade_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_r;
    logic [7:0] cmd_g;
    logic [7:0] cmd_b;
    logic [7:0] cmd_rate;
    logic       gamma_en;

    modport master (
        output cmd_valid, cmd_r, cmd_g, cmd_b, cmd_rate, gamma_en,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_r, cmd_g, cmd_b, cmd_rate, gamma_en,
        output cmd_ready
    );
endinterface

// File: rtl/gamma_lut.sv
// rtl/gamma_lut.sv - combinational gamma-2.2 lookup for one colour channel
module gamma_lut
    import rgb_ctrl_pkg::*;
(
    input  logic [7:0] i_level,
    output logic [7:0] o_duty
);
    assign o_duty = GAMMA_LUT[i_level];
endmodule

// File: rtl/rgb_fade_ctrl.sv
// rtl/rgb_fade_ctrl.sv - PWM tick generator and frame-aligned colour fade sequencer for pwm_rgb
module rgb_fade_ctrl
    import rgb_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rgb_fade_ctrl_if.slave   cmd,
    output logic             tick,
    output logic [7:0]       duty_r,
    output logic [7:0]       duty_g,
    output logic [7:0]       duty_b,
    output logic             busy,
    output logic             done
);
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_div;
    logic        r_tick;
    logic [7:0]  r_pcnt;
    fade_state_t r_state;
    fade_state_t w_state_nxt;
    logic [7:0]  r_cur_r, r_cur_g, r_cur_b;
    logic [7:0]  r_tgt_r, r_tgt_g, r_tgt_b;
    logic [7:0]  r_rate;
    logic [7:0]  r_step_cnt;
    logic [7:0]  r_duty_r, r_duty_g, r_duty_b;
    logic        r_done;

    logic        w_frame_end;
    logic        w_at_tgt;
    logic        w_accept;
    logic        w_load;
    logic        w_done_nxt;
    logic [7:0]  w_step_cnt_nxt;
    logic [7:0]  w_nxt_r, w_nxt_g, w_nxt_b;
    logic [7:0]  w_gam_r, w_gam_g, w_gam_b;

    // Last cycle of a PWM period: the pwm_rgb counter wraps 255->0 at the coming edge.
    assign w_frame_end = r_tick && (r_pcnt == 8'hFF);
    assign w_at_tgt    = (r_cur_r == r_tgt_r) && (r_cur_g == r_tgt_g) && (r_cur_b == r_tgt_b);

    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign busy          = (r_state == ST_FADE);
    assign done          = r_done;
    assign tick          = r_tick;
    assign duty_r        = r_duty_r;
    assign duty_g        = r_duty_g;
    assign duty_b        = r_duty_b;

    gamma_lut u_gamma_r (.i_level(w_nxt_r), .o_duty(w_gam_r));
    gamma_lut u_gamma_g (.i_level(w_nxt_g), .o_duty(w_gam_g));
    gamma_lut u_gamma_b (.i_level(w_nxt_b), .o_duty(w_gam_b));

    // Tick divider and the mirror of the pwm_rgb period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
            r_pcnt <= '0;
        end else begin
            if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div + 16'd1;
                r_tick <= 1'b0;
            end
            if (r_tick) r_pcnt <= r_pcnt + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, frame pacing and next linear levels; levels only move on a frame_end.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_load         = 1'b0;
        w_done_nxt     = 1'b0;
        w_step_cnt_nxt = r_step_cnt;
        w_nxt_r        = r_cur_r;
        w_nxt_g        = r_cur_g;
        w_nxt_b        = r_cur_b;
        case (r_state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_accept       = 1'b1;
                    w_step_cnt_nxt = '0;
                    w_state_nxt    = ST_FADE;
                end
            end
            ST_FADE: begin
                if (w_at_tgt) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_frame_end) begin
                    if (r_rate == 8'd0) begin
                        w_load  = 1'b1;
                        w_nxt_r = r_tgt_r;
                        w_nxt_g = r_tgt_g;
                        w_nxt_b = r_tgt_b;
                    end else if (r_step_cnt == r_rate - 8'd1) begin
                        w_load         = 1'b1;
                        w_step_cnt_nxt = '0;
                        w_nxt_r        = step_toward(r_cur_r, r_tgt_r);
                        w_nxt_g        = step_toward(r_cur_g, r_tgt_g);
                        w_nxt_b        = step_toward(r_cur_b, r_tgt_b);
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, levels, frame counter, done pulse and duty load at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt_r    <= '0;
            r_tgt_g    <= '0;
            r_tgt_b    <= '0;
            r_rate     <= '0;
            r_step_cnt <= '0;
            r_cur_r    <= '0;
            r_cur_g    <= '0;
            r_cur_b    <= '0;
            r_duty_r   <= '0;
            r_duty_g   <= '0;
            r_duty_b   <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tgt_r <= cmd.cmd_r;
                r_tgt_g <= cmd.cmd_g;
                r_tgt_b <= cmd.cmd_b;
                r_rate  <= cmd.cmd_rate;
            end
            if (w_load) begin
                r_cur_r  <= w_nxt_r;
                r_cur_g  <= w_nxt_g;
                r_cur_b  <= w_nxt_b;
                r_duty_r <= cmd.gamma_en ? w_gam_r : w_nxt_r;
                r_duty_g <= cmd.gamma_en ? w_gam_g : w_nxt_g;
                r_duty_b <= cmd.gamma_en ? w_gam_b : w_nxt_b;
            end
            r_step_cnt <= w_step_cnt_nxt;
            r_done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb/tb_rgb_fade_ctrl.sv - directed self-checking bench for rgb_fade_ctrl
module tb_rgb_fade_ctrl;
    localparam int TICK_DIV = 4;
    localparam int PERIOD   = 256 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] duty_r, duty_g, duty_b;
    int         cyc;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] exp_r2_r [6] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
    logic [7:0] exp_r2_g [6] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};

    rgb_fade_ctrl_if cmd_bus ();

    rgb_fade_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd_bus),
        .tick   (tick),
        .duty_r (duty_r),
        .duty_g (duty_g),
        .duty_b (duty_b),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_duty(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        check_eq(tag, {8'd0, duty_r, duty_g, duty_b}, {8'd0, r, g, b});
    endtask

    task automatic cycle_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) cycle_step();
    endtask

    function automatic int next_fe(input int e);
        return ((e - 1) / PERIOD + 1) * PERIOD + 1;
    endfunction

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_tick"},  32'(tick), 32'd0);
        check_duty({tag, "_duty"}, 8'd0, 8'd0, 8'd0);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_done"},  32'(done), 32'd0);
        check_eq({tag, "_ready"}, 32'(cmd_bus.cmd_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cycle_step();
        check_reset_outs("rst");
        cycle_step();
        rst_n = 1'b1;
    endtask

    task automatic send_cmd(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] rate, input logic gam, output int e0);
        logic rdy;
        cmd_bus.cmd_r     = r;
        cmd_bus.cmd_g     = g;
        cmd_bus.cmd_b     = b;
        cmd_bus.cmd_rate  = rate;
        cmd_bus.gamma_en  = gam;
        cmd_bus.cmd_valid = 1'b1;
        e0 = -1;
        for (int k = 0; k < 4 * PERIOD && e0 < 0; k++) begin
            rdy = cmd_bus.cmd_ready;
            cycle_step();
            if (rdy) e0 = cyc;
        end
        cmd_bus.cmd_valid = 1'b0;
        if (e0 < 0) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            e0 = cyc;
        end
    endtask

    initial begin
        int e0;
        int fe;
        int f1;
        int k;
        int n_done;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_r     = 8'd0;
        cmd_bus.cmd_g     = 8'd0;
        cmd_bus.cmd_b     = 8'd0;
        cmd_bus.cmd_rate  = 8'd0;
        cmd_bus.gamma_en  = 1'b0;

        // Reset and idle tick cadence
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            cycle_step();
            check_eq($sformatf("tick_c%0d", c), 32'(tick), 32'((c % TICK_DIV) == 0));
        end
        check_duty("idle_duty", 8'd0, 8'd0, 8'd0);
        check_eq("idle_ready", 32'(cmd_bus.cmd_ready), 32'd1);

        // Rate 0 jump, no gamma
        send_cmd(8'd255, 8'd0, 8'd128, 8'd0, 1'b0, e0);
        check_eq("acc_busy", 32'(busy), 32'd1);
        check_eq("acc_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        fe = next_fe(e0);
        run_to(fe - 1);
        check_duty("r0_pre", 8'd0, 8'd0, 8'd0);
        run_to(fe);
        check_duty("r0_load", 8'd255, 8'd0, 8'd128);
        check_eq("r0_done_early", 32'(done), 32'd0);
        run_to(fe + 1);
        check_eq("r0_done", 32'(done), 32'd1);
        check_eq("r0_busy_end", 32'(busy), 32'd0);
        check_eq("r0_ready_end", 32'(cmd_bus.cmd_ready), 32'd1);
        run_to(fe + 2);
        check_eq("r0_done_fall", 32'(done), 32'd0);
        run_to(fe + 300);
        check_duty("r0_hold", 8'd255, 8'd0, 8'd128);

        // Rate 0 jump with gamma
        do_reset();
        send_cmd(8'd255, 8'd0, 8'd128, 8'd0, 1'b1, e0);
        fe = next_fe(e0);
        run_to(fe);
        check_duty("gam_load", 8'd255, 8'd0, 8'd56);
        run_to(fe + 1);
        check_eq("gam_done", 32'(done), 32'd1);

        // Rate 2 ramp to (3,1,0)
        do_reset();
        send_cmd(8'd3, 8'd1, 8'd0, 8'd2, 1'b0, e0);
        f1 = next_fe(e0);
        n_done = 0;
        k = 0;
        while (cyc < f1 + 5 * PERIOD + 4) begin
            cycle_step();
            if (done) n_done++;
            if (k < 6 && cyc == f1 + k * PERIOD) begin
                check_duty($sformatf("r2_frame%0d", k + 1), exp_r2_r[k], exp_r2_g[k], 8'd0);
                check_eq($sformatf("r2_busy%0d", k + 1), 32'(busy), 32'd1);
                k++;
            end
        end
        check_eq("r2_frames_seen", 32'(k), 32'd6);
        check_eq("r2_done_pulses", 32'(n_done), 32'd1);
        check_eq("r2_busy_end", 32'(busy), 32'd0);

        // Command held while busy waits for IDLE
        do_reset();
        send_cmd(8'd10, 8'd20, 8'd30, 8'd0, 1'b0, e0);
        cmd_bus.cmd_r     = 8'd9;
        cmd_bus.cmd_rate  = 8'd1;
        cmd_bus.cmd_valid = 1'b1;
        fe = next_fe(e0);
        run_to(600);
        check_eq("hold_ready_mid", 32'(cmd_bus.cmd_ready), 32'd0);
        run_to(fe);
        check_eq("hold_ready_fe", 32'(cmd_bus.cmd_ready), 32'd0);
        check_duty("hold_a_load", 8'd10, 8'd20, 8'd30);
        run_to(fe + 1);
        check_eq("hold_a_done", 32'(done), 32'd1);
        check_eq("hold_ready_idle", 32'(cmd_bus.cmd_ready), 32'd1);
        run_to(fe + 2);
        check_eq("hold_b_busy", 32'(busy), 32'd1);
        check_eq("hold_b_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        check_duty("hold_a_intact", 8'd10, 8'd20, 8'd30);
        cmd_bus.cmd_valid = 1'b0;
        fe = next_fe(fe + 2);
        run_to(fe);
        check_duty("hold_b_load", 8'd9, 8'd20, 8'd30);
        run_to(fe + 1);
        check_eq("hold_b_done", 32'(done), 32'd1);

        // Reset in the middle of a fade
        do_reset();
        send_cmd(8'd5, 8'd5, 8'd5, 8'd1, 1'b0, e0);
        fe = next_fe(e0);
        run_to(fe + PERIOD);
        check_duty("mid_progress", 8'd2, 8'd2, 8'd2);
        run_to(fe + PERIOD + 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        for (int c = 0; c < 3; c++) begin
            cycle_step();
            check_eq($sformatf("midrst_done%0d", c), 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        send_cmd(8'd2, 8'd1, 8'd0, 8'd1, 1'b0, e0);
        fe = next_fe(e0);
        run_to(fe);
        check_duty("post_rst_f1", 8'd1, 8'd1, 8'd0);
        run_to(fe + PERIOD);
        check_duty("post_rst_f2", 8'd2, 8'd1, 8'd0);
        run_to(fe + PERIOD + 1);
        check_eq("post_rst_done", 32'(done), 32'd1);

        // Gamma sampled at a later load
        send_cmd(8'd64, 8'd255, 8'd1, 8'd0, 1'b1, e0);
        fe = next_fe(e0);
        run_to(fe);
        check_duty("gam2_load", 8'd12, 8'd255, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
